// File: rtl/antenna_frame_framer.sv
// antenna_frame_framer: keeps the first DESIRED_FRAME_SIZE samples of each frame and streams them out through a small FIFO
module antenna_frame_framer #(
  parameter int FRAME_SIZE         = 2048,
  parameter int DESIRED_FRAME_SIZE = 2000,
  parameter int INPUT_DATA_WIDTH   = 16,
  parameter int INPUT_ELEMENTS     = 4,
  parameter int FIFO_DEPTH         = 16,
  localparam int DW = INPUT_ELEMENTS * 2 * INPUT_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof,
  output logic [15:0]   frame_cnt,
  output logic          overflow,
  output logic          sync_err
);
  localparam int IW = $clog2(FRAME_SIZE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + 2;
  typedef enum logic [1:0] {IDLE, KEEP, SKIP} state_t;
  state_t r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx, w_idx_nxt;
  logic w_adv, w_keep, w_resync;
  logic r_st_vld;
  logic [EW-1:0] r_st_ent, w_head;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_empty, w_full, w_rd, w_push;
  logic [15:0] r_frame_cnt;
  logic r_overflow, r_sync_err;
  // Frame tracking: an in_sof always restarts at index 0; otherwise the index advances in KEEP/SKIP
  always_comb begin
    w_adv       = in_valid && (r_state != IDLE || in_sof);
    w_keep      = w_adv && (in_sof || r_state == KEEP);
    w_resync    = in_valid && in_sof && r_state != IDLE && r_idx != '0;
    w_idx       = in_sof ? '0 : r_idx;
    w_idx_nxt   = r_idx;
    w_state_nxt = r_state;
    if (w_adv) begin
      w_idx_nxt   = (w_idx == IW'(FRAME_SIZE - 1)) ? '0 : w_idx + 1'b1;
      w_state_nxt = (w_idx == IW'(FRAME_SIZE - 1)) ? KEEP :
                    (w_idx == IW'(DESIRED_FRAME_SIZE - 1)) ? SKIP :
                    w_keep ? KEEP : SKIP;
    end
  end
  // State, index and the one-deep capture stage feeding the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_st_vld <= 1'b0;
      r_st_ent <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_st_vld <= w_keep;
      r_st_ent <= {w_idx == '0, w_idx == IW'(DESIRED_FRAME_SIZE - 1), in_data};
    end
  end
  assign w_empty   = r_wp == r_rp;
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_rd      = !w_empty && out_ready;
  assign w_push    = r_st_vld && (!w_full || w_rd);
  assign w_head    = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign out_valid = !w_empty;
  assign {out_sof, out_eof, out_data} = w_head;
  assign frame_cnt = r_frame_cnt;
  assign overflow  = r_overflow;
  assign sync_err  = r_sync_err;
  // FIFO storage, not reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= r_st_ent;
  end
  // FIFO pointers, completed-frame counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      if (w_rd && out_eof) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (r_st_vld && w_full && !w_rd) r_overflow <= 1'b1;
      if (w_resync) r_sync_err <= 1'b1;
    end
  end
endmodule
